// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the single-cycle debug CPU: issues cpu_en pulses, owns the debug mux
// select and reports why execution stopped. Optional macro STEP_COUNT_EN enables multi-instruction STEP.
module cpu_run_ctrl #(
   parameter int NUM_BP   = 4,
   parameter int BP_IDX_W = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_op,
   input  logic [BP_IDX_W-1:0] cmd_idx,
   input  logic [31:0]         cmd_arg,
   input  logic [31:0]         pc_chk,
   output logic                cpu_en,
   output logic                debug,
   output logic                halted,
   output logic                evt_valid,
   output logic [1:0]          evt_cause,
   output logic [31:0]         instr_cnt
);

   typedef enum logic [2:0] {
      ST_HALT  = 3'd0,
      ST_PREP  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_CHECK = 3'd3,
      ST_STOP  = 3'd4
   } state_e;

   typedef enum logic {
      MODE_STEP = 1'b0,
      MODE_RUN  = 1'b1
   } mode_e;

   localparam logic [2:0] OP_STEP    = 3'd1;
   localparam logic [2:0] OP_RUN     = 3'd2;
   localparam logic [2:0] OP_HALT    = 3'd3;
   localparam logic [2:0] OP_SET_BP  = 3'd4;
   localparam logic [2:0] OP_CLR_BP  = 3'd5;
   localparam logic [2:0] OP_CLR_ALL = 3'd6;

   localparam logic [1:0] CAUSE_STEP = 2'd0;
   localparam logic [1:0] CAUSE_BP   = 2'd1;
   localparam logic [1:0] CAUSE_HALT = 2'd2;

   state_e             state_q, state_d;
   mode_e              mode_q, mode_d;
   logic               halt_pend_q, halt_pend_d;
   logic [NUM_BP-1:0]  bp_valid_q, bp_valid_d;
   logic [31:0]        bp_addr_q [NUM_BP];
   logic [31:0]        bp_addr_d [NUM_BP];
   logic [1:0]         evt_cause_q, evt_cause_d;
   logic [31:0]        instr_cnt_q, instr_cnt_d;
   logic               cpu_en_q, debug_q, halted_q, evt_valid_q;
   logic               cmd_fire_s, run_state_s, bp_hit_s, step_last_s;

`ifdef STEP_COUNT_EN
   logic [15:0]        step_rem_q, step_rem_d;

   function automatic logic [15:0] step_load(input logic [15:0] cnt);
      step_load = (cnt == 16'd0) ? 16'd1 : cnt;
   endfunction

   assign step_last_s = (step_rem_q == 16'd1);
`else
   assign step_last_s = 1'b1;
`endif

   assign run_state_s = (state_q == ST_PREP) || (state_q == ST_EXEC) || (state_q == ST_CHECK);
   assign cmd_fire_s  = cmd_valid && cmd_ready;

   // Only HALT may interrupt a running sequence; everything else stalls until the CPU is stopped.
   always_comb begin
      cmd_ready = 1'b0;
      case (state_q)
         ST_HALT:                    cmd_ready = 1'b1;
         ST_PREP, ST_EXEC, ST_CHECK: cmd_ready = (cmd_op == OP_HALT);
         default:                    cmd_ready = 1'b0;
      endcase
   end

   // Breakpoint comparators against the post-execution PC
   always_comb begin
      bp_hit_s = 1'b0;
      for (int i = 0; i < NUM_BP; i++) begin
         bp_hit_s = bp_hit_s | (bp_valid_q[i] & (bp_addr_q[i] == pc_chk));
      end
   end

   // Next-state logic for the sequencer and its bookkeeping registers
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      halt_pend_d = halt_pend_q;
      bp_valid_d  = bp_valid_q;
      bp_addr_d   = bp_addr_q;
      evt_cause_d = evt_cause_q;
      instr_cnt_d = instr_cnt_q;
`ifdef STEP_COUNT_EN
      step_rem_d  = step_rem_q;
`endif
      case (state_q)
         ST_HALT: begin
            if (cmd_fire_s) begin
               case (cmd_op)
                  OP_STEP: begin
                     state_d = ST_PREP;
                     mode_d  = MODE_STEP;
`ifdef STEP_COUNT_EN
                     step_rem_d = step_load(cmd_arg[15:0]);
`endif
                  end
                  OP_RUN: begin
                     state_d = ST_PREP;
                     mode_d  = MODE_RUN;
                  end
                  OP_SET_BP: begin
                     bp_addr_d[cmd_idx]  = cmd_arg;
                     bp_valid_d[cmd_idx] = 1'b1;
                  end
                  OP_CLR_BP:  bp_valid_d[cmd_idx] = 1'b0;
                  OP_CLR_ALL: bp_valid_d = '0;
                  default:    state_d = ST_HALT;
               endcase
            end else begin
               state_d = ST_HALT;
            end
         end
         ST_PREP: state_d = ST_EXEC;
         ST_EXEC: begin
            state_d     = ST_CHECK;
            instr_cnt_d = instr_cnt_q + 32'd1;
         end
         ST_CHECK: begin
            // halt_pend_q (not _d) is used so a HALT landing in this cycle waits for the next CHECK
            if ((mode_q == MODE_STEP) && step_last_s) begin
               state_d     = ST_STOP;
               evt_cause_d = CAUSE_STEP;
            end else if ((mode_q == MODE_RUN) && bp_hit_s) begin
               state_d     = ST_STOP;
               evt_cause_d = CAUSE_BP;
            end else if (halt_pend_q) begin
               state_d     = ST_STOP;
               evt_cause_d = CAUSE_HALT;
            end else begin
               state_d = ST_EXEC;
`ifdef STEP_COUNT_EN
               if (mode_q == MODE_STEP) begin
                  step_rem_d = step_rem_q - 16'd1;
               end else begin
                  step_rem_d = step_rem_q;
               end
`endif
            end
         end
         ST_STOP: begin
            state_d     = ST_HALT;
            halt_pend_d = 1'b0;
         end
         default: state_d = ST_HALT;
      endcase

      if (run_state_s && cmd_fire_s && (cmd_op == OP_HALT)) begin
         halt_pend_d = 1'b1;
      end else begin
         halt_pend_d = halt_pend_d;
      end
   end

   // State and bookkeeping registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_HALT;
         mode_q      <= MODE_STEP;
         halt_pend_q <= 1'b0;
         bp_valid_q  <= '0;
         evt_cause_q <= CAUSE_STEP;
         instr_cnt_q <= 32'd0;
         for (int i = 0; i < NUM_BP; i++) begin
            bp_addr_q[i] <= 32'd0;
         end
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         halt_pend_q <= halt_pend_d;
         bp_valid_q  <= bp_valid_d;
         evt_cause_q <= evt_cause_d;
         instr_cnt_q <= instr_cnt_d;
         for (int i = 0; i < NUM_BP; i++) begin
            bp_addr_q[i] <= bp_addr_d[i];
         end
      end
   end

`ifdef STEP_COUNT_EN
   // Remaining-instruction counter for multi-step
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         step_rem_q <= 16'd1;
      end else begin
         step_rem_q <= step_rem_d;
      end
   end
`endif

   // Glitch-free registered outputs decoded from the next state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cpu_en_q    <= 1'b0;
         debug_q     <= 1'b1;
         halted_q    <= 1'b1;
         evt_valid_q <= 1'b0;
      end else begin
         cpu_en_q    <= (state_d == ST_EXEC);
         debug_q     <= (state_d == ST_HALT) || (state_d == ST_STOP);
         halted_q    <= (state_d == ST_HALT);
         evt_valid_q <= (state_d == ST_STOP);
      end
   end

   assign cpu_en    = cpu_en_q;
   assign debug     = debug_q;
   assign halted    = halted_q;
   assign evt_valid = evt_valid_q;
   assign evt_cause = evt_cause_q;
   assign instr_cnt = instr_cnt_q;

endmodule
